ysyx_23060203_ifu: RTL and testbench

Instruction fetch unit: the consumer of the PC register's `pc`. It accepts one fetch address per handshake from the PC/EXU side and issues a single-beat read on the instruction-memory read channel (AXI4-Lite AR/R subset). It returns the instruction word, its PC and an error code to the IDU over a valid/ready handshake. At most one fetch is outstanding; the block sits between the PC register and the decode stage.

---
 rtl/ysyx_23060203_pkg.sv | 19 +
 rtl/ysyx_23060203_ifu_ohold.sv | 39 +++
 rtl/ysyx_23060203_ifu.sv | 118 +++++++++++
 tb/tb_ysyx_23060203_ifu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060203_pkg.sv
// Shared types and constants for the ysyx_23060203 core: IFU FSM states, fetch error codes,
// the canonical NOP and the reset PC used by the PC register.
package ysyx_23060203_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StOut
    } ifu_state_t;

    localparam logic [1:0] IFU_ERR_NONE     = 2'd0;
    localparam logic [1:0] IFU_ERR_ACCESS   = 2'd1;
    localparam logic [1:0] IFU_ERR_MISALIGN = 2'd2;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060203_ifu_ohold.sv
// Holding register for the IFU result {inst, inst_pc, inst_err}; it only updates on load,
// so the payload stays stable while the IDU stalls.
module ysyx_23060203_ifu_ohold
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    input  logic [1:0]      load_err,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_err
);

    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;
    logic [1:0]      err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inst_q <= XLEN'(INST_NOP);
            pc_q   <= '0;
            err_q  <= IFU_ERR_NONE;
        end else if (load) begin
            inst_q <= load_inst;
            pc_q   <= load_pc;
            err_q  <= load_err;
        end
    end

    assign inst     = inst_q;
    assign inst_pc  = pc_q;
    assign inst_err = err_q;

endmodule

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite AR/R fetch, result to the IDU over
// valid/ready. Define YSYX_23060203_IFU_MISALIGN_EN to trap misaligned PCs without a memory access.
module ysyx_23060203_ifu
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    output logic            pc_ready,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_err,
    output logic            inst_valid,
    input  logic            inst_ready
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ld;
    logic [XLEN-1:0] ld_inst;
    logic [XLEN-1:0] ld_pc;
    logic [1:0]      ld_err;
    logic            pc_mis;

`ifdef YSYX_23060203_IFU_MISALIGN_EN
    assign pc_mis = (pc[1:0] != 2'b00);
`else
    assign pc_mis = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ld         = 1'b0;
        ld_inst    = XLEN'(INST_NOP);
        ld_pc      = pc_q;
        ld_err     = IFU_ERR_NONE;
        pc_ready   = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        inst_valid = 1'b0;

        unique case (state_q)
            StIdle: pc_ready = 1'b1;
            StAr: begin
                arvalid = 1'b1;
                if (arready) state_d = StR;
            end
            StR: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_d = StOut;
                    ld      = 1'b1;
                    if (rresp != 2'b00) begin
                        ld_err = IFU_ERR_ACCESS;
                    end else begin
                        ld_inst = rdata;
                    end
                end
            end
            StOut: begin
                inst_valid = 1'b1;
                pc_ready   = inst_ready;
                if (inst_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accepting a new PC overrides the OUT->IDLE step, giving the bubble-free bypass.
        if (pc_valid && pc_ready) begin
            pc_d    = pc;
            state_d = StAr;
            if (pc_mis) begin
                state_d = StOut;
                ld      = 1'b1;
                ld_pc   = pc;
                ld_err  = IFU_ERR_MISALIGN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign araddr = {pc_q[XLEN-1:2], 2'b00};

    ysyx_23060203_ifu_ohold #(
        .XLEN(XLEN)
    ) u_ohold (
        .clk      (clk),
        .rstn     (rstn),
        .load     (ld),
        .load_inst(ld_inst),
        .load_pc  (ld_pc),
        .load_err (ld_err),
        .inst     (inst),
        .inst_pc  (inst_pc),
        .inst_err (inst_err)
    );

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Self-checking bench for ysyx_23060203_ifu: directed scenarios plus randomized fetches,
// checked against a transaction-level model of the expected fetch result.
module tb_ysyx_23060203_ifu;
    import ysyx_23060203_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;
    logic        inst_valid;
    logic        inst_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic [1:0]  exp_err;

    ysyx_23060203_ifu #(
        .XLEN(32)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pc_valid  (pc_valid),
        .pc        (pc),
        .pc_ready  (pc_ready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_err  (inst_err),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit misaligned(input logic [31:0] a);
`ifdef YSYX_23060203_IFU_MISALIGN_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        #1;
        chkb({tag, "_pc_ready"}, pc_ready, 1'b1);
        chkb({tag, "_inst_valid"}, inst_valid, 1'b0);
        chkb({tag, "_arvalid"}, arvalid, 1'b0);
        chkb({tag, "_rready"}, rready, 1'b0);
        chkw({tag, "_inst"}, inst, INST_NOP);
        chkw({tag, "_inst_pc"}, inst_pc, 32'h0);
        chkw({tag, "_araddr"}, araddr, 32'h0);
        chkw({tag, "_inst_err"}, {30'b0, inst_err}, 32'h0);
    endtask

    // Present a PC; works from IDLE or (as bypass) from OUT.
    task automatic issue(input logic [31:0] addr, output bit skipped);
        pc_valid   = 1'b1;
        pc         = addr;
        inst_ready = 1'b1;
        rvalid     = 1'($urandom);
        rdata      = $urandom;
        arready    = 1'($urandom);
        #1 chkb("pc_ready", pc_ready, 1'b1);
        step();
        pc_valid   = 1'b0;
        pc         = $urandom;
        inst_ready = 1'b0;
        skipped    = misaligned(addr);
        if (skipped) begin
            exp_inst = INST_NOP;
            exp_pc   = addr;
            exp_err  = IFU_ERR_MISALIGN;
        end
    endtask

    task automatic mem_phase(input logic [31:0] addr, input int ar_wait, input int r_wait,
                             input logic [31:0] data, input logic [1:0] resp);
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            rvalid  = 1'($urandom);
            rdata   = $urandom;
            #1;
            chkb("arvalid_wait", arvalid, 1'b1);
            chkw("araddr_wait", araddr, addr & 32'hffff_fffc);
            chkb("inst_valid_ar", inst_valid, 1'b0);
            chkb("rready_ar", rready, 1'b0);
            step();
        end
        arready = 1'b1;
        rvalid  = 1'($urandom);
        #1;
        chkb("arvalid", arvalid, 1'b1);
        chkw("araddr", araddr, addr & 32'hffff_fffc);
        step();
        arready = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            rvalid  = 1'b0;
            arready = 1'($urandom);
            #1;
            chkb("rready_wait", rready, 1'b1);
            chkb("arvalid_r", arvalid, 1'b0);
            step();
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        #1 chkb("rready", rready, 1'b1);
        step();
        rvalid   = 1'b0;
        rresp    = 2'($urandom);
        exp_inst = (resp != 2'b00) ? INST_NOP : data;
        exp_err  = (resp != 2'b00) ? IFU_ERR_ACCESS : IFU_ERR_NONE;
        exp_pc   = addr;
    endtask

    task automatic check_out(input int hold);
        for (int i = 0; i < hold; i++) begin
            inst_ready = 1'b0;
            pc_valid   = 1'($urandom);
            pc         = $urandom;
            #1;
            chkb("hold_valid", inst_valid, 1'b1);
            chkb("hold_pc_ready", pc_ready, 1'b0);
            chkw("hold_inst", inst, exp_inst);
            chkw("hold_inst_pc", inst_pc, exp_pc);
            chkw("hold_inst_err", {30'b0, inst_err}, {30'b0, exp_err});
            step();
        end
        pc_valid = 1'b0;
        #1;
        chkb("inst_valid", inst_valid, 1'b1);
        chkb("arvalid_out", arvalid, 1'b0);
        chkw("inst", inst, exp_inst);
        chkw("inst_pc", inst_pc, exp_pc);
        chkw("inst_err", {30'b0, inst_err}, {30'b0, exp_err});
    endtask

    task automatic pop();
        inst_ready = 1'b1;
        pc_valid   = 1'b0;
        step();
        inst_ready = 1'b0;
        #1;
        chkb("pop_valid", inst_valid, 1'b0);
        chkb("pop_pc_ready", pc_ready, 1'b1);
    endtask

    task automatic fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic [1:0] resp, input int hold);
        bit sk;
        issue(addr, sk);
        if (sk) begin
            #1 chkb("arvalid_mis", arvalid, 1'b0);
        end else begin
            mem_phase(addr, ar_wait, r_wait, data, resp);
        end
        check_out(hold);
    endtask

    initial begin
        bit sk;
        logic [31:0] a;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        step();

        // Minimum-latency fetch of the reset PC.
        fetch(RESET_PC, 0, 0, 32'h0000_0297, 2'b00, 0);
        pop();

        // AR stall, then hold OUT for 4 cycles and bypass straight into the next fetch.
        fetch(32'h8000_0004, 5, 0, 32'h1234_5678, 2'b00, 4);
        fetch(32'h8000_0008, 0, 2, 32'hcafe_f00d, 2'b00, 1);
        pop();

        // Access fault.
        fetch(32'h8000_000c, 1, 1, 32'hdead_beef, 2'b10, 0);
        pop();

        // Misaligned PC: trapped when enabled, otherwise word-aligned access.
        fetch(32'h8000_0002, 0, 0, 32'h0000_0517, 2'b00, 2);
        pop();

        // Reset while waiting in R abandons the fetch.
        issue(32'h8000_0010, sk);
        arready = 1'b1;
        step();
        arready = 1'b0;
        #1 chkb("in_r_rready", rready, 1'b1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_reset_values("midreset");
        fetch(32'h8000_0014, 0, 0, 32'h0050_0093, 2'b00, 0);
        pop();

        // Randomized fetch stream with random stalls, faults and bypass.
        for (int n = 0; n < 60; n++) begin
            a = 32'h8000_0000 | 32'($urandom_range(0, 16'hffff));
            if ($urandom_range(0, 3) != 0) a = a & 32'hffff_fffc;
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) pop();
        end
        pop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
